// File: rtl/cmd_link_pkg.sv
// rtl/cmd_link_pkg.sv - shared command-link types and widths
package cmd_link_pkg;
  localparam int CMD_W  = 16;
  localparam int BYTE_W = 8;

  typedef enum logic {WAIT_HIGH, WAIT_LOW} rcv_state_t;
endpackage

// File: rtl/UART_rx.sv
// rtl/UART_rx.sv - 8N1 UART receiver, rdy held until clr_rdy or next start bit
module UART_rx
  import cmd_link_pkg::*;
#(
  parameter int BAUD_DIV = 2604
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RX,
  input  logic              clr_rdy,
  output logic [BYTE_W-1:0] rx_data,
  output logic              rdy
);
  localparam int CW = $clog2(BAUD_DIV + 1);

  logic              rx_ff1_q, rx_ff2_q, busy_q, rdy_q;
  logic [CW-1:0]     baud_q;
  logic [3:0]        bit_q;
  logic [BYTE_W-1:0] shift_q;

  // Samples land mid-bit: half a period after the start edge, then every full period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ff1_q <= 1'b1;
      rx_ff2_q <= 1'b1;
      busy_q   <= 1'b0;
      rdy_q    <= 1'b0;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
    end else begin
      rx_ff1_q <= RX;
      rx_ff2_q <= rx_ff1_q;
      if (clr_rdy) rdy_q <= 1'b0;
      if (!busy_q) begin
        if (!rx_ff2_q) begin
          busy_q <= 1'b1;
          baud_q <= CW'(BAUD_DIV / 2);
          bit_q  <= '0;
          rdy_q  <= 1'b0;
        end
      end else if (baud_q == '0) begin
        baud_q <= CW'(BAUD_DIV - 1);
        bit_q  <= bit_q + 4'd1;
        if (bit_q == 4'd9) begin
          busy_q <= 1'b0;
          rdy_q  <= 1'b1;
        end else begin
          shift_q <= {rx_ff2_q, shift_q[BYTE_W-1:1]};
        end
      end else begin
        baud_q <= baud_q - CW'(1);
      end
    end
  end

  assign rx_data = shift_q;
  assign rdy     = rdy_q;
endmodule

// File: rtl/UART_tx.sv
// rtl/UART_tx.sv - 8N1 UART transmitter with one-cycle tx_done at end of stop bit
module UART_tx
  import cmd_link_pkg::*;
#(
  parameter int BAUD_DIV = 2604
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trmt,
  input  logic [BYTE_W-1:0] tx_data,
  output logic              TX,
  output logic              tx_done
);
  localparam int CW = $clog2(BAUD_DIV + 1);

  logic [BYTE_W+1:0] shift_q;
  logic              busy_q, done_q;
  logic [CW-1:0]     baud_q;
  logic [3:0]        bit_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      baud_q  <= '0;
      bit_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (trmt && !busy_q) begin
        shift_q <= {1'b1, tx_data, 1'b0};
        busy_q  <= 1'b1;
        baud_q  <= CW'(BAUD_DIV - 1);
        bit_q   <= '0;
      end else if (busy_q) begin
        if (baud_q == '0) begin
          shift_q <= {1'b1, shift_q[BYTE_W+1:1]};
          baud_q  <= CW'(BAUD_DIV - 1);
          bit_q   <= bit_q + 4'd1;
          if (bit_q == 4'd9) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end else begin
          baud_q <= baud_q - CW'(1);
        end
      end
    end
  end

  assign TX      = shift_q[0];
  assign tx_done = done_q;
endmodule

// File: rtl/cmd_assembler.sv
// rtl/cmd_assembler.sv - two-byte command FSM; inter-byte timeout under CMD_TIMEOUT_EN
module cmd_assembler
  import cmd_link_pkg::*;
#(
  parameter int TMO_CYCLES = 1_000_000,
  parameter int TMO_W      = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_rdy,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              clr_cmd_rdy,
  output logic              clr_rdy,
  output logic [CMD_W-1:0]  cmd,
  output logic              cmd_rdy,
  output logic              cmd_tmo
);
  rcv_state_t        state_q, state_d;
  logic [BYTE_W-1:0] high_q, high_d;
  logic [CMD_W-1:0]  cmd_q, cmd_d;
  logic              cmd_rdy_q, cmd_rdy_d;
  logic              tmo_hit;

`ifdef CMD_TIMEOUT_EN
  logic [TMO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + TMO_W'(1);
    if (state_q == WAIT_HIGH) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tmo_hit = (state_q == WAIT_LOW) && (cnt_q == TMO_W'(TMO_CYCLES - 1));
`else
  logic [TMO_W-1:0] unused_tmo;
  assign unused_tmo = TMO_W'(TMO_CYCLES);
  assign tmo_hit    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= WAIT_HIGH;
      high_q    <= '0;
      cmd_q     <= '0;
      cmd_rdy_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      high_q    <= high_d;
      cmd_q     <= cmd_d;
      cmd_rdy_q <= cmd_rdy_d;
    end
  end

  // Setting cmd_rdy is assigned after the acknowledge so a coincident set wins.
  always_comb begin
    state_d   = state_q;
    high_d    = high_q;
    cmd_d     = cmd_q;
    cmd_rdy_d = cmd_rdy_q;
    if (clr_cmd_rdy) cmd_rdy_d = 1'b0;
    case (state_q)
      WAIT_HIGH: begin
        if (rx_rdy) begin
          high_d    = rx_data;
          cmd_rdy_d = 1'b0;
          state_d   = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (rx_rdy) begin
          cmd_d     = {high_q, rx_data};
          cmd_rdy_d = 1'b1;
          state_d   = WAIT_HIGH;
        end else if (tmo_hit) begin
          high_d  = '0;
          state_d = WAIT_HIGH;
        end
      end
      default: state_d = WAIT_HIGH;
    endcase
  end

  always_comb begin
    clr_rdy = 1'b0;
    cmd_tmo = 1'b0;
    case (state_q)
      WAIT_HIGH: clr_rdy = rx_rdy;
      WAIT_LOW: begin
        clr_rdy = rx_rdy;
        cmd_tmo = !rx_rdy && tmo_hit;
      end
      default: clr_rdy = 1'b0;
    endcase
  end

  assign cmd     = cmd_q;
  assign cmd_rdy = cmd_rdy_q;
endmodule

// File: rtl/uart_cmd_rcvr.sv
// rtl/uart_cmd_rcvr.sv - UART command receiver top with response transmit handshake
// Optional inter-byte timeout enabled by defining CMD_TIMEOUT_EN.
module uart_cmd_rcvr
  import cmd_link_pkg::*;
#(
  parameter int TMO_CYCLES = 1_000_000,
  parameter int TMO_W      = 20,
  parameter int BAUD_DIV   = 2604
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RX,
  input  logic              clr_cmd_rdy,
  input  logic              snd_resp,
  input  logic [BYTE_W-1:0] resp,
  output logic              TX,
  output logic [CMD_W-1:0]  cmd,
  output logic              cmd_rdy,
  output logic              resp_sent,
  output logic              tx_busy,
  output logic              cmd_tmo
);
  logic              rx_rdy, clr_rdy, tx_done, accept;
  logic [BYTE_W-1:0] rx_data;
  logic              trmt_q, tx_busy_q, resp_sent_q;
  logic [BYTE_W-1:0] tx_data_q;

  UART_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk     (clk),
    .rst_n   (rst_n),
    .RX      (RX),
    .clr_rdy (clr_rdy),
    .rx_data (rx_data),
    .rdy     (rx_rdy)
  );

  cmd_assembler #(.TMO_CYCLES(TMO_CYCLES), .TMO_W(TMO_W)) u_asm (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_rdy      (rx_rdy),
    .rx_data     (rx_data),
    .clr_cmd_rdy (clr_cmd_rdy),
    .clr_rdy     (clr_rdy),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .cmd_tmo     (cmd_tmo)
  );

  UART_tx #(.BAUD_DIV(BAUD_DIV)) u_tx (
    .clk     (clk),
    .rst_n   (rst_n),
    .trmt    (trmt_q),
    .tx_data (tx_data_q),
    .TX      (TX),
    .tx_done (tx_done)
  );

  // trmt is registered so the transmitter loads tx_data after it has been latched.
  assign accept = snd_resp && !tx_busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trmt_q      <= 1'b0;
      tx_busy_q   <= 1'b0;
      resp_sent_q <= 1'b0;
      tx_data_q   <= '0;
    end else begin
      trmt_q      <= accept;
      resp_sent_q <= tx_done;
      if (accept) begin
        tx_data_q <= resp;
        tx_busy_q <= 1'b1;
      end else if (tx_done) begin
        tx_busy_q <= 1'b0;
      end
    end
  end

  assign tx_busy   = tx_busy_q;
  assign resp_sent = resp_sent_q;
endmodule

// File: tb/tb_uart_cmd_rcvr.sv
// tb/tb_uart_cmd_rcvr.sv - directed table-driven bench for uart_cmd_rcvr
module tb_uart_cmd_rcvr;
  localparam int BAUD = 16;
`ifdef CMD_TIMEOUT_EN
  localparam int EXP_TMO = 1;
`else
  localparam int EXP_TMO = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RX = 1'b1;
  logic        clr_cmd_rdy = 1'b0;
  logic        snd_resp = 1'b0;
  logic [7:0]  resp = 8'h00;
  logic        TX, cmd_rdy, resp_sent, tx_busy, cmd_tmo;
  logic [15:0] cmd;

  int checks = 0;
  int errors = 0;
  int sent_cnt = 0;
  int tmo_cnt = 0;

  uart_cmd_rcvr #(.TMO_CYCLES(5000), .TMO_W(13), .BAUD_DIV(BAUD)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .clr_cmd_rdy(clr_cmd_rdy),
    .snd_resp(snd_resp), .resp(resp), .TX(TX), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .resp_sent(resp_sent), .tx_busy(tx_busy), .cmd_tmo(cmd_tmo)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (resp_sent) sent_cnt++;
    if (cmd_tmo) tmo_cnt++;
  end

  typedef struct {
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic        clr;
    logic [15:0] exp_cmd;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    @(posedge clk); #1 RX = b;
    repeat (BAUD - 1) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    drive_bit(1'b0);
    for (int j = 0; j < 8; j++) drive_bit(b[j]);
    drive_bit(1'b1);
  endtask

  task automatic wait_clr_rdy(input int limit, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (dut.clr_rdy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 clr_cmd_rdy = 1'b1;
    @(posedge clk); #1 clr_cmd_rdy = 1'b0;
  endtask

  task automatic pulse_resp(input logic [7:0] r);
    @(posedge clk); #1 resp = r; snd_resp = 1'b1;
    @(posedge clk); #1 snd_resp = 1'b0;
  endtask

  task automatic decode_tx(output logic [7:0] b, output bit ok);
    ok = 1'b0;
    b  = 8'h00;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!TX) begin ok = 1'b1; break; end
    end
    if (ok) begin
      repeat (BAUD / 2) @(negedge clk);
      if (TX) ok = 1'b0;
      for (int j = 0; j < 8; j++) begin
        repeat (BAUD) @(negedge clk);
        b[j] = TX;
      end
      repeat (BAUD) @(negedge clk);
      if (!TX) ok = 1'b0;
    end
  endtask

  vec_t        v;
  logic [15:0] prev_cmd;
  logic [7:0]  got;
  bit          ok;
  int          n, base;

  initial begin
    vecs[0] = '{hi: 8'hA5, lo: 8'h3C, clr: 1'b1, exp_cmd: 16'hA53C};
    vecs[1] = '{hi: 8'h12, lo: 8'h34, clr: 1'b0, exp_cmd: 16'h1234};
    vecs[2] = '{hi: 8'hFF, lo: 8'h00, clr: 1'b1, exp_cmd: 16'hFF00};
    vecs[3] = '{hi: 8'h00, lo: 8'h01, clr: 1'b0, exp_cmd: 16'h0001};

    repeat (3) @(negedge clk);
    check("rst_tx", 32'(TX), 32'(1'b1));
    check("rst_cmd", 32'(cmd), 32'h0);
    check("rst_cmd_rdy", 32'(cmd_rdy), 32'h0);
    check("rst_tx_busy", 32'(tx_busy), 32'h0);
    check("rst_resp_sent", 32'(resp_sent), 32'h0);
    check("rst_cmd_tmo", 32'(cmd_tmo), 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);

    prev_cmd = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      v = vecs[i];
      send_byte(v.hi);
      @(negedge clk);
      check("hi_cmd_held", 32'(cmd), 32'(prev_cmd));
      check("hi_rdy_clear", 32'(cmd_rdy), 32'h0);
      fork
        send_byte(v.lo);
        begin
          wait_clr_rdy(400, ok);
          check("lo_consumed", 32'(ok), 32'h1);
          check("lo_rdy_before", 32'(cmd_rdy), 32'h0);
          @(negedge clk);
          check("lat_cmd", 32'(cmd), 32'(v.exp_cmd));
          check("lat_rdy", 32'(cmd_rdy), 32'h1);
        end
      join
      @(negedge clk);
      check("rdy_sticky", 32'(cmd_rdy), 32'h1);
      if (v.clr) begin
        pulse_clr();
        @(negedge clk);
        check("rdy_ack", 32'(cmd_rdy), 32'h0);
        check("cmd_after_ack", 32'(cmd), 32'(v.exp_cmd));
      end
      prev_cmd = v.exp_cmd;
    end

`ifdef CMD_TIMEOUT_EN
    fork
      send_byte(8'h12);
      begin
        wait_clr_rdy(400, ok);
        check("tmo_byte_seen", 32'(ok), 32'h1);
        n = 0;
        for (int k = 0; k < 6000; k++) begin
          @(negedge clk);
          n++;
          if (cmd_tmo) break;
        end
        check("tmo_delay", 32'(n), 32'd5000);
      end
    join
    @(negedge clk);
    check("tmo_one_cycle", 32'(cmd_tmo), 32'h0);
    check("tmo_cmd_kept", 32'(cmd), 32'h0001);
    check("tmo_rdy_kept", 32'(cmd_rdy), 32'h1);
    send_byte(8'h34);
    send_byte(8'h56);
    @(negedge clk);
    check("post_tmo_cmd", 32'(cmd), 32'h3456);
`endif

    pulse_clr();
    send_byte(8'hAB);
    fork
      send_byte(8'hCD);
      begin
        wait_clr_rdy(400, ok);
        clr_cmd_rdy = 1'b1;
        @(posedge clk); #1 clr_cmd_rdy = 1'b0;
      end
    join
    @(negedge clk);
    check("set_wins_rdy", 32'(cmd_rdy), 32'h1);
    check("set_wins_cmd", 32'(cmd), 32'hABCD);

    base = sent_cnt;
    fork
      begin
        pulse_resp(8'hA5);
        @(negedge clk);
        check("busy_after_accept", 32'(tx_busy), 32'h1);
        repeat (60) @(posedge clk);
        pulse_resp(8'h5A);
      end
      begin
        decode_tx(got, ok);
        check("resp1_frame", 32'(ok), 32'h1);
        check("resp1_byte", 32'(got), 32'hA5);
      end
    join
    repeat (300) @(negedge clk);
    check("resp1_sent_once", 32'(sent_cnt - base), 32'd1);
    check("resp1_idle", 32'(tx_busy), 32'h0);
    fork
      pulse_resp(8'h3C);
      begin
        decode_tx(got, ok);
        check("resp2_byte", 32'(got), 32'h3C);
      end
    join
    repeat (40) @(negedge clk);
    check("resp2_sent", 32'(sent_cnt - base), 32'd2);

    send_byte(8'h77);
    pulse_resp(8'h81);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    @(negedge clk);
    check("pre_rst_tx_low", 32'(TX), 32'h0);
    check("pre_rst_busy", 32'(tx_busy), 32'h1);
    @(posedge clk); #1 rst_n = 1'b0; RX = 1'b1;
    @(negedge clk);
    check("mid_rst_tx", 32'(TX), 32'h1);
    check("mid_rst_cmd", 32'(cmd), 32'h0);
    check("mid_rst_rdy", 32'(cmd_rdy), 32'h0);
    check("mid_rst_busy", 32'(tx_busy), 32'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    send_byte(8'hBE);
    send_byte(8'hEF);
    @(negedge clk);
    check("beef_cmd", 32'(cmd), 32'hBEEF);
    check("beef_rdy", 32'(cmd_rdy), 32'h1);
    check("tmo_pulses", 32'(tmo_cnt), 32'(EXP_TMO));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
